// File: rtl/cache_mem_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// cache_mem_arbiter_if : cache-side and RAM-side signals of the memory arbiter
// Revision 1.0
// ---------------------------------------------------------------------------
interface cache_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              iwait;
    logic [DATA_W-1:0] iload;
    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic              dwait;
    logic [DATA_W-1:0] dload;
    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic [DATA_W-1:0] ramload;
    logic              ram_ready;
    logic              timeout_err;

    // master: the arbiter itself; slave: the caches and RAM around it
    modport master (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore,
               timeout_err
    );
    modport slave (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore,
               timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// cache_mem_arbiter : shares one RAM port between icache and dcache, one word
//                     per grant, with a bounded wait for RAM completion
// Revision 1.0
// ---------------------------------------------------------------------------
module cache_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  wire logic            CLK,
    input  wire logic            RST,
    cache_mem_arbiter_if.master  bus
);
    localparam int               CNT_W      = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_owner_d;
    logic              r_last_d;
    logic              r_write;
    logic [CNT_W-1:0]  r_count;
    logic              r_iwait;
    logic              r_dwait;
    logic [DATA_W-1:0] r_iload;
    logic [DATA_W-1:0] r_dload;
    logic              r_ram_ren;
    logic              r_ram_wen;
    logic [ADDR_W-1:0] r_ramaddr;
    logic [DATA_W-1:0] r_ramstore;
    logic              r_timeout_err;

    logic w_i_req;
    logic w_d_req;
    logic w_grant_d;
    logic w_grant_wr;

    assign w_i_req    = bus.iREN;
    assign w_d_req    = bus.dREN | bus.dWEN;
    // on contention the side that did not own the previous grant wins
    assign w_grant_d  = w_d_req & (~w_i_req | ~r_last_d);
    assign w_grant_wr = w_grant_d & bus.dWEN;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state       <= S_IDLE;
            r_owner_d     <= 1'b0;
            r_last_d      <= 1'b0;
            r_write       <= 1'b0;
            r_count       <= '0;
            r_iwait       <= 1'b1;
            r_dwait       <= 1'b1;
            r_iload       <= '0;
            r_dload       <= '0;
            r_ram_ren     <= 1'b0;
            r_ram_wen     <= 1'b0;
            r_ramaddr     <= '0;
            r_ramstore    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_i_req | w_d_req) begin
                        r_owner_d  <= w_grant_d;
                        r_write    <= w_grant_wr;
                        r_ram_ren  <= ~w_grant_wr;
                        r_ram_wen  <= w_grant_wr;
                        r_ramaddr  <= w_grant_d ? bus.daddr : bus.iaddr;
                        r_ramstore <= w_grant_d ? bus.dstore : '0;
                        r_count    <= '0;
                        r_state    <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (bus.ram_ready) begin
                        r_ram_ren <= 1'b0;
                        r_ram_wen <= 1'b0;
                        if (r_owner_d) begin
                            r_dwait <= 1'b0;
                            if (!r_write) r_dload <= bus.ramload;
                        end else begin
                            r_iwait <= 1'b0;
                            if (!r_write) r_iload <= bus.ramload;
                        end
                        r_state <= S_RESP;
                    end else if (r_count == C_CNT_LAST) begin
                        // abort: the requester still gets its completion pulse
                        r_ram_ren     <= 1'b0;
                        r_ram_wen     <= 1'b0;
                        r_timeout_err <= 1'b1;
                        if (r_owner_d) begin
                            r_dwait <= 1'b0;
                            r_dload <= '0;
                        end else begin
                            r_iwait <= 1'b0;
                            r_iload <= '0;
                        end
                        r_state <= S_RESP;
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    r_iwait  <= 1'b1;
                    r_dwait  <= 1'b1;
                    r_last_d <= r_owner_d;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.iwait       = r_iwait;
    assign bus.dwait       = r_dwait;
    assign bus.iload       = r_iload;
    assign bus.dload       = r_dload;
    assign bus.ramREN      = r_ram_ren;
    assign bus.ramWEN      = r_ram_wen;
    assign bus.ramaddr     = r_ramaddr;
    assign bus.ramstore    = r_ramstore;
    assign bus.timeout_err = r_timeout_err;
endmodule
`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cache_mem_arbiter : directed stimulus, transaction-age reference model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_cache_mem_arbiter;
    localparam int TO = 4;

    logic clk;
    logic rst;
    logic started;
    int   n_cmp;
    int   n_err;

    cache_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    cache_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reference: a transaction is granted, lives m_age access cycles, then one response cycle.
    logic        m_busy, m_owner_d, m_write, m_last_d;
    int          m_age;
    logic        m_iwait, m_dwait, m_ren, m_wen, m_terr;
    logic [31:0] m_iload, m_dload, m_addr, m_store;
    logic        w_i_req, w_d_req, w_pick_d;

    assign w_i_req  = bus.iREN;
    assign w_d_req  = bus.dREN | bus.dWEN;
    assign w_pick_d = (w_i_req && w_d_req) ? !m_last_d : w_d_req;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0; m_owner_d <= 1'b0; m_write <= 1'b0; m_last_d <= 1'b0;
            m_age <= 0; m_iwait <= 1'b1; m_dwait <= 1'b1; m_ren <= 1'b0; m_wen <= 1'b0;
            m_terr <= 1'b0; m_iload <= '0; m_dload <= '0; m_addr <= '0; m_store <= '0;
        end else if (!m_busy) begin
            if (w_i_req || w_d_req) begin
                m_busy    <= 1'b1;
                m_age     <= 1;
                m_owner_d <= w_pick_d;
                m_write   <= w_pick_d && bus.dWEN;
                m_ren     <= !(w_pick_d && bus.dWEN);
                m_wen     <= w_pick_d && bus.dWEN;
                m_addr    <= w_pick_d ? bus.daddr : bus.iaddr;
                m_store   <= w_pick_d ? bus.dstore : 32'h0;
            end
        end else if (m_age != 0) begin
            if (bus.ram_ready || m_age == TO) begin
                m_ren <= 1'b0;
                m_wen <= 1'b0;
                m_age <= 0;
                if (m_owner_d) m_dwait <= 1'b0; else m_iwait <= 1'b0;
                if (!bus.ram_ready) begin
                    m_terr <= 1'b1;
                    if (m_owner_d) m_dload <= 32'h0; else m_iload <= 32'h0;
                end else if (!m_write) begin
                    if (m_owner_d) m_dload <= bus.ramload; else m_iload <= bus.ramload;
                end
            end else begin
                m_age <= m_age + 1;
            end
        end else begin
            m_iwait  <= 1'b1;
            m_dwait  <= 1'b1;
            m_last_d <= m_owner_d;
            m_busy   <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (started && !rst) begin
            chk("iwait", bus.iwait, m_iwait);
            chk("dwait", bus.dwait, m_dwait);
            chk("iload", bus.iload, m_iload);
            chk("dload", bus.dload, m_dload);
            chk("ramREN", bus.ramREN, m_ren);
            chk("ramWEN", bus.ramWEN, m_wen);
            chk("ramaddr", bus.ramaddr, m_addr);
            chk("ramstore", bus.ramstore, m_store);
            chk("timeout_err", bus.timeout_err, m_terr);
            chk("waits_exclusive", bus.iwait | bus.dwait, 1'b1);
            chk("strobes_exclusive", bus.ramREN & bus.ramWEN, 1'b0);
        end
    end

    task automatic serve(input logic exp_wen, input logic [31:0] exp_addr,
                         input logic [31:0] rdata, input int delay);
        int n;
        n = 0;
        while (!(bus.ramREN || bus.ramWEN) && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            n_cmp++;
            n_err++;
            $display("FAIL serve_strobe: no RAM strobe within 20 cycles, expected addr %0h", exp_addr);
        end else begin
            chk("serve_wen", bus.ramWEN, exp_wen);
            chk("serve_addr", bus.ramaddr, exp_addr);
            repeat (delay) tick();
            bus.ram_ready = 1'b1;
            bus.ramload   = rdata;
            tick();
            bus.ram_ready = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_cmp = 0; n_err = 0; started = 1'b0;
        rst = 1'b1;
        bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0;
        bus.daddr = 0; bus.dstore = 0; bus.ramload = 0; bus.ram_ready = 0;
        #1;
        chk("rst_iwait", bus.iwait, 1'b1);
        chk("rst_dwait", bus.dwait, 1'b1);
        chk("rst_ramREN", bus.ramREN, 1'b0);
        chk("rst_terr", bus.timeout_err, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        started = 1'b1;

        // icache read, RAM answers in the first access cycle
        bus.iREN = 1; bus.iaddr = 32'h40;
        tick();
        chk("t2_ren_c1", bus.ramREN, 1'b1);
        chk("t2_addr_c1", bus.ramaddr, 32'h40);
        bus.ram_ready = 1; bus.ramload = 32'hDEADBEEF;
        tick();
        bus.ram_ready = 0;
        chk("t2_ren_c2", bus.ramREN, 1'b0);
        chk("t2_iwait_c2", bus.iwait, 1'b0);
        chk("t2_iload_c2", bus.iload, 32'hDEADBEEF);
        bus.iREN = 0;
        tick();
        chk("t2_iwait_c3", bus.iwait, 1'b1);
        tick();

        // contention from reset-equivalent history (last owner I): D, I, D, I
        bus.iREN = 1; bus.iaddr = 32'h100;
        bus.dWEN = 1; bus.daddr = 32'h80; bus.dstore = 32'h1234;
        tick();
        chk("t3_wen_c1", bus.ramWEN, 1'b1);
        chk("t3_store_c1", bus.ramstore, 32'h1234);
        serve(1'b1, 32'h80, 32'h0, 0);
        chk("t3_dwait", bus.dwait, 1'b0);
        serve(1'b0, 32'h100, 32'hA5A5_0001, 1);
        chk("t3_iload", bus.iload, 32'hA5A5_0001);
        serve(1'b1, 32'h80, 32'h0, 2);
        serve(1'b0, 32'h100, 32'hA5A5_0002, 0);
        bus.iREN = 0; bus.dWEN = 0;
        tick();
        tick();

        // dcache read then a read that never completes
        bus.dREN = 1; bus.daddr = 32'h210;
        serve(1'b0, 32'h210, 32'h55AA, 1);
        chk("t4_dload_ok", bus.dload, 32'h55AA);
        bus.daddr = 32'h200;
        tick();
        tick();
        for (int i = 0; i < TO; i++) begin
            chk("t4_ren_held", bus.ramREN, 1'b1);
            tick();
        end
        chk("t4_ren_drop", bus.ramREN, 1'b0);
        chk("t4_dwait", bus.dwait, 1'b0);
        chk("t4_dload", bus.dload, 32'h0);
        chk("t4_terr", bus.timeout_err, 1'b1);
        bus.dREN = 0;
        tick();
        chk("t4_dwait_hi", bus.dwait, 1'b1);
        chk("t4_terr_sticky", bus.timeout_err, 1'b1);
        tick();

        // write whose requester changes its mind mid-access
        bus.dWEN = 1; bus.daddr = 32'h300; bus.dstore = 32'hCAFE;
        tick();
        chk("t5_wen_c1", bus.ramWEN, 1'b1);
        tick();
        bus.daddr = 32'h999; bus.dstore = 32'h777; bus.dWEN = 0;
        tick();
        chk("t5_addr_c3", bus.ramaddr, 32'h300);
        chk("t5_store_c3", bus.ramstore, 32'hCAFE);
        chk("t5_wen_c3", bus.ramWEN, 1'b1);
        bus.ram_ready = 1;
        tick();
        bus.ram_ready = 0;
        chk("t5_dwait_c4", bus.dwait, 1'b0);
        chk("t5_dload_hold", bus.dload, 32'h0);
        tick();
        chk("t5_dwait_c5", bus.dwait, 1'b1);
        tick();
        chk("t5_no_regrant", bus.ramWEN | bus.ramREN, 1'b0);

        // asynchronous reset in the middle of an access
        bus.dREN = 1; bus.daddr = 32'h400;
        tick();
        tick();
        chk("t1_ren_pre", bus.ramREN, 1'b1);
        rst = 1'b1;
        #1;
        chk("t1_ren", bus.ramREN, 1'b0);
        chk("t1_iwait", bus.iwait, 1'b1);
        chk("t1_dwait", bus.dwait, 1'b1);
        chk("t1_terr", bus.timeout_err, 1'b0);
        chk("t1_addr", bus.ramaddr, 32'h0);
        bus.dREN = 0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
